// File: rtl/cond_unit_if.sv
// cond_unit_if -- Execute-stage bundle into the condition unit, plus the
// qualified controls it registers towards the Memory stage.
//   master : the pipeline side (drives Execute controls, reads results)
//   slave  : cond_unit side
interface cond_unit_if;
  // Execute-stage inputs
  logic       valid_e;
  logic       stall_e;
  logic       flush_e;
  logic [3:0] cond_e;
  logic [1:0] flagw_e;
  logic [3:0] alu_flags;     // {N,Z,C,V}
  logic       pcs_e;
  logic       regw_e;
  logic       memw_e;
  logic       branch_e;
  logic       pred_taken_e;
  // Results
  logic       cond_ex;       // combinational
  logic       redirect;      // combinational
  logic [3:0] flags;         // architectural {N,Z,C,V}
  logic       pcsrc_m;
  logic       regwrite_m;
  logic       memwrite_m;
  logic       valid_m;

  modport master (
    output valid_e, stall_e, flush_e, cond_e, flagw_e, alu_flags,
           pcs_e, regw_e, memw_e, branch_e, pred_taken_e,
    input  cond_ex, redirect, flags, pcsrc_m, regwrite_m, memwrite_m, valid_m
  );

  modport slave (
    input  valid_e, stall_e, flush_e, cond_e, flagw_e, alu_flags,
           pcs_e, regw_e, memw_e, branch_e, pred_taken_e,
    output cond_ex, redirect, flags, pcsrc_m, regwrite_m, memwrite_m, valid_m
  );
endinterface

// File: rtl/cond_unit.sv
// cond_unit -- ARM-style condition check and flag register for the Execute
// stage. Evaluates the condition field against the architectural flags,
// qualifies the write/branch controls and registers them into Memory.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : cond_unit_if.slave (Execute inputs, Memory-stage outputs)
//   cnt_*    : performance counters, present only with COND_UNIT_PERF_EN
// Optional feature macro: COND_UNIT_PERF_EN (saturating commit / squash /
// mispredict counters, CNT_W bits each).
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef COND_UNIT_PERF_EN
  output logic [CNT_W-1:0] cnt_commit,
  output logic [CNT_W-1:0] cnt_squash,
  output logic [CNT_W-1:0] cnt_mispred,
`endif
  cond_unit_if.slave       bus
);

  logic [3:0] flags_q, flags_d;
  logic       pcsrc_q, pcsrc_d;
  logic       regw_q, regw_d;
  logic       memw_q, memw_d;
  logic       vld_q, vld_d;

  logic n, z, c, v;
  logic cond_ok;
  logic live;      // valid, not stalled, not flushed
  logic commit;
  logic squash;    // live but condition failed

  assign {n, z, c, v} = flags_q;

  // Condition evaluated from the registered flags only: an update made by the
  // previous instruction is seen one cycle later, never bypassed.
  always_comb begin
    cond_ok = 1'b1;
    unique case (bus.cond_e)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~c | z;
      4'b1010: cond_ok = (n == v);
      4'b1011: cond_ok = (n != v);
      4'b1100: cond_ok = ~z & (n == v);
      4'b1101: cond_ok = z | (n != v);
      default: cond_ok = 1'b1;   // 1110 / 1111 always execute
    endcase
  end

  assign live   = bus.valid_e & ~bus.stall_e & ~bus.flush_e;
  assign commit = live & cond_ok;
  assign squash = live & ~cond_ok;

  always_comb begin
    flags_d = flags_q;
    if (commit && bus.flagw_e[1]) flags_d[3:2] = bus.alu_flags[3:2];
    if (commit && bus.flagw_e[0]) flags_d[1:0] = bus.alu_flags[1:0];
    pcsrc_d = commit & bus.pcs_e;
    regw_d  = commit & bus.regw_e;
    memw_d  = commit & bus.memw_e;
    // A failed condition still retires as a valid no-op; stall/flush bubble.
    vld_d   = commit | squash;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= 4'b0000;
      pcsrc_q <= 1'b0;
      regw_q  <= 1'b0;
      memw_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      pcsrc_q <= pcsrc_d;
      regw_q  <= regw_d;
      memw_q  <= memw_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.cond_ex    = cond_ok;
  assign bus.redirect   = live & bus.branch_e & (cond_ok != bus.pred_taken_e);
  assign bus.flags      = flags_q;
  assign bus.pcsrc_m    = pcsrc_q;
  assign bus.regwrite_m = regw_q;
  assign bus.memwrite_m = memw_q;
  assign bus.valid_m    = vld_q;

`ifdef COND_UNIT_PERF_EN
  logic [CNT_W-1:0] cnt_commit_q, cnt_commit_d;
  logic [CNT_W-1:0] cnt_squash_q, cnt_squash_d;
  logic [CNT_W-1:0] cnt_mispred_q, cnt_mispred_d;

  // Saturating increments: stick at all-ones instead of wrapping.
  always_comb begin
    cnt_commit_d  = cnt_commit_q;
    cnt_squash_d  = cnt_squash_q;
    cnt_mispred_d = cnt_mispred_q;
    if (commit && (cnt_commit_q != '1))         cnt_commit_d  = cnt_commit_q + 1'b1;
    if (squash && (cnt_squash_q != '1))         cnt_squash_d  = cnt_squash_q + 1'b1;
    if (bus.redirect && (cnt_mispred_q != '1))  cnt_mispred_d = cnt_mispred_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_commit_q  <= '0;
      cnt_squash_q  <= '0;
      cnt_mispred_q <= '0;
    end else begin
      cnt_commit_q  <= cnt_commit_d;
      cnt_squash_q  <= cnt_squash_d;
      cnt_mispred_q <= cnt_mispred_d;
    end
  end

  assign cnt_commit  = cnt_commit_q;
  assign cnt_squash  = cnt_squash_q;
  assign cnt_mispred = cnt_mispred_q;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit -- directed self-checking bench for cond_unit.
module tb_cond_unit;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cond_unit_if bus ();

`ifdef COND_UNIT_PERF_EN
  logic [CNT_W-1:0] cnt_commit, cnt_squash, cnt_mispred;
`endif

  cond_unit #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
`ifdef COND_UNIT_PERF_EN
    .cnt_commit (cnt_commit),
    .cnt_squash (cnt_squash),
    .cnt_mispred(cnt_mispred),
`endif
    .bus        (bus)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.valid_e = 0; bus.stall_e = 0; bus.flush_e = 0; bus.cond_e = 4'b1110;
    bus.flagw_e = 2'b00; bus.alu_flags = 4'b0000; bus.pcs_e = 0; bus.regw_e = 0;
    bus.memw_e = 0; bus.branch_e = 0; bus.pred_taken_e = 0;
  endtask

  // Unconditional flag-setting instruction to put the flags in a known state.
  task automatic set_flags(input logic [3:0] f);
    idle();
    bus.valid_e = 1; bus.cond_e = 4'b1110; bus.flagw_e = 2'b11; bus.alu_flags = f;
    tick();
    idle();
    n_run++;
    if (bus.flags !== f) begin
      n_fail++; $display("FAIL set_flags: got %b want %b", bus.flags, f);
    end
  endtask

  task automatic do_reset();
    idle();
    #2 reset_n = 0;
    repeat (2) tick();
    reset_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    repeat (3) tick();
    n_run++;
    if ({bus.flags, bus.valid_m, bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m} !== 8'b0000_0000) begin
      n_fail++;
      $display("FAIL reset_state: got flags=%b v=%b p=%b r=%b m=%b want 0000 0 0 0 0",
               bus.flags, bus.valid_m, bus.pcsrc_m, bus.regwrite_m, bus.memwrite_m);
    end
    reset_n = 1;
    tick();
  endtask

  task automatic test_adds_eq();
    idle();
    bus.valid_e = 1; bus.cond_e = 4'b1110; bus.flagw_e = 2'b11; bus.alu_flags = 4'b0100;
    bus.regw_e = 1;
    tick();
    n_run++;
    if (bus.flags !== 4'b0100) begin
      n_fail++; $display("FAIL adds_flags: got %b want 0100", bus.flags);
    end
    n_run++;
    if ({bus.valid_m, bus.regwrite_m, bus.pcsrc_m, bus.memwrite_m} !== 4'b1100) begin
      n_fail++; $display("FAIL adds_ctrl: got %b want 1100",
                         {bus.valid_m, bus.regwrite_m, bus.pcsrc_m, bus.memwrite_m});
    end
    idle();
    bus.valid_e = 1; bus.cond_e = 4'b0000;
    #1;
    n_run++;
    if (bus.cond_ex !== 1'b1) begin
      n_fail++; $display("FAIL eq_after_adds: got %b want 1", bus.cond_ex);
    end
    idle();
  endtask

  task automatic test_ands_partial();
    set_flags(4'b1001);
    bus.valid_e = 1; bus.cond_e = 4'b1110; bus.flagw_e = 2'b10; bus.alu_flags = 4'b0110;
    tick();
    idle();
    n_run++;
    if (bus.flags !== 4'b0101) begin
      n_fail++; $display("FAIL ands_nz_only: got %b want 0101", bus.flags);
    end
  endtask

  task automatic test_beq_mispredict();
    set_flags(4'b0000);
    bus.valid_e = 1; bus.cond_e = 4'b0000; bus.branch_e = 1; bus.pred_taken_e = 1;
    bus.pcs_e = 1;
    #1;
    n_run++;
    if ({bus.cond_ex, bus.redirect} !== 2'b01) begin
      n_fail++; $display("FAIL beq_comb: got cond_ex=%b redirect=%b want 0 1",
                         bus.cond_ex, bus.redirect);
    end
    tick();
    idle();
    n_run++;
    if ({bus.pcsrc_m, bus.valid_m} !== 2'b01) begin
      n_fail++; $display("FAIL beq_mem: got pcsrc_m=%b valid_m=%b want 0 1",
                         bus.pcsrc_m, bus.valid_m);
    end
  endtask

  task automatic test_stall_flush();
    set_flags(4'b0000);
    // Flush and stall together: bubble, no flag write, no redirect.
    bus.valid_e = 1; bus.cond_e = 4'b1110; bus.flagw_e = 2'b11; bus.alu_flags = 4'b1111;
    bus.stall_e = 1; bus.flush_e = 1; bus.branch_e = 1; bus.regw_e = 1;
    #1;
    n_run++;
    if (bus.redirect !== 1'b0) begin
      n_fail++; $display("FAIL stall_flush_redirect: got %b want 0", bus.redirect);
    end
    tick();
    n_run++;
    if ({bus.flags, bus.valid_m, bus.regwrite_m} !== 6'b0000_00) begin
      n_fail++; $display("FAIL stall_flush_mem: got flags=%b v=%b r=%b want 0000 0 0",
                         bus.flags, bus.valid_m, bus.regwrite_m);
    end
    // Stall alone also bubbles and holds flags.
    bus.flush_e = 0; bus.branch_e = 0;
    tick();
    idle();
    n_run++;
    if ({bus.flags, bus.valid_m} !== 5'b0000_0) begin
      n_fail++; $display("FAIL stall_only: got flags=%b v=%b want 0000 0",
                         bus.flags, bus.valid_m);
    end
  endtask

  task automatic test_failed_cond();
    set_flags(4'b0000);
    bus.valid_e = 1; bus.cond_e = 4'b0000; bus.flagw_e = 2'b11; bus.alu_flags = 4'b1111;
    bus.regw_e = 1; bus.memw_e = 1;
    tick();
    idle();
    n_run++;
    if ({bus.flags, bus.valid_m, bus.regwrite_m, bus.memwrite_m} !== 7'b0000_100) begin
      n_fail++; $display("FAIL failed_cond: got flags=%b v=%b r=%b m=%b want 0000 1 0 0",
                         bus.flags, bus.valid_m, bus.regwrite_m, bus.memwrite_m);
    end
  endtask

  // Full condition table against hand-derived masks (bit i = cond code i).
  task automatic test_cond_table();
    logic [3:0]  fv [3];
    logic [15:0] mk [3];
    fv[0] = 4'b0100; mk[0] = 16'hE6A9;
    fv[1] = 4'b1010; mk[1] = 16'hE996;
    fv[2] = 4'b1001; mk[2] = 16'hD65A;
    for (int k = 0; k < 3; k++) begin
      set_flags(fv[k]);
      for (int cc = 0; cc < 16; cc++) begin
        bus.cond_e = 4'(cc);
        #1;
        n_run++;
        if (bus.cond_ex !== mk[k][cc]) begin
          n_fail++; $display("FAIL cond_table flags=%b cond=%0d: got %b want %b",
                             fv[k], cc, bus.cond_ex, mk[k][cc]);
        end
      end
      idle();
    end
  endtask

  // Flag write is visible to the very next instruction.
  task automatic test_back_to_back();
    set_flags(4'b0000);
    bus.valid_e = 1; bus.cond_e = 4'b1110; bus.flagw_e = 2'b11; bus.alu_flags = 4'b0100;
    tick();
    bus.cond_e = 4'b0000; bus.flagw_e = 2'b11; bus.alu_flags = 4'b0000; bus.regw_e = 1;
    tick();
    n_run++;
    if ({bus.flags, bus.regwrite_m} !== 5'b0000_1) begin
      n_fail++; $display("FAIL b2b_second: got flags=%b r=%b want 0000 1",
                         bus.flags, bus.regwrite_m);
    end
    tick();
    idle();
    n_run++;
    if ({bus.valid_m, bus.regwrite_m} !== 2'b10) begin
      n_fail++; $display("FAIL b2b_third: got v=%b r=%b want 1 0",
                         bus.valid_m, bus.regwrite_m);
    end
  endtask

  task automatic test_async_reset();
    set_flags(4'b1111);
    bus.valid_e = 1; bus.cond_e = 4'b1110; bus.regw_e = 1;
    tick();
    n_run++;
    if (bus.regwrite_m !== 1'b1) begin
      n_fail++; $display("FAIL async_pre: got regwrite_m=%b want 1", bus.regwrite_m);
    end
    #2 reset_n = 0;
    #1;
    n_run++;
    if ({bus.regwrite_m, bus.flags} !== 5'b0_0000) begin
      n_fail++; $display("FAIL async_reset: got r=%b flags=%b want 0 0000",
                         bus.regwrite_m, bus.flags);
    end
    idle();
    #2 reset_n = 1;
    tick();
  endtask

`ifdef COND_UNIT_PERF_EN
  task automatic test_perf_saturate();
    do_reset();
    bus.valid_e = 1; bus.cond_e = 4'b1110;
    repeat (5) tick();
    n_run++;
    if (cnt_commit !== 4'd5) begin
      n_fail++; $display("FAIL perf_commit5: got %0d want 5", cnt_commit);
    end
    repeat (15) tick();
    n_run++;
    if (cnt_commit !== 4'd15) begin
      n_fail++; $display("FAIL perf_commit20: got %0d want 15", cnt_commit);
    end
    tick();
    idle();
    tick();
    n_run++;
    if (cnt_commit !== 4'd15) begin
      n_fail++; $display("FAIL perf_hold: got %0d want 15", cnt_commit);
    end
    // One squash and one mispredict (same failed BEQ predicted taken).
    do_reset();
    bus.valid_e = 1; bus.cond_e = 4'b0000; bus.branch_e = 1; bus.pred_taken_e = 1;
    tick();
    idle();
    n_run++;
    if ({cnt_commit, cnt_squash, cnt_mispred} !== {4'd0, 4'd1, 4'd1}) begin
      n_fail++; $display("FAIL perf_squash_mispred: got %0d %0d %0d want 0 1 1",
                         cnt_commit, cnt_squash, cnt_mispred);
    end
  endtask
`endif

  initial begin
    idle();
    test_reset();
    test_adds_eq();
    test_ands_partial();
    test_beq_mispredict();
    test_stall_flush();
    test_failed_cond();
    test_cond_table();
    test_back_to_back();
    test_async_reset();
`ifdef COND_UNIT_PERF_EN
    test_perf_saturate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the performance counters.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port valid_e  input  1  Execute-stage instruction is valid.
REQ-005 SHALL have port stall_e  input  1  hold Execute stage; no state commit.
REQ-006 SHALL have port flush_e  input  1  squash Execute-stage instruction.
REQ-007 SHALL have port cond_e  input  4  ARM condition field.
REQ-008 SHALL have port flagw_e  input  2  ALU-decoder FlagW; bit1 writes N,Z and bit0 writes C,V.
REQ-009 SHALL have port alu_flags  input  4  ALU result flags {N,Z,C,V}.
REQ-010 SHALL have port pcs_e, regw_e, memw_e, branch_e  input  1 each  unqualified controls.
REQ-011 SHALL have port pred_taken_e  input  1  branch-predictor taken guess.
REQ-012 SHALL have port cond_ex  output  1  condition passes (combinational).
REQ-013 SHALL have port redirect  output  1  branch mispredict (combinational).
REQ-014 SHALL have port flags  output  4  architectural {N,Z,C,V} register.
REQ-015 SHALL have port pcsrc_m, regwrite_m, memwrite_m, valid_m  output  1 each  registered, qualified controls to Memory stage.

Function
REQ-016 SHALL evaluate cond_ex from the flags register as follows: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); 1110 and 1111 are always true.
REQ-017 SHALL define a commit as valid_e & cond_ex & !stall_e & !flush_e.
REQ-018 SHALL, on a commit, load N,Z from alu_flags when flagw_e[1]=1 and load C,V when flagw_e[0]=1, and otherwise hold them.
REQ-019 SHALL make a flag update visible to the instruction in Execute on the next cycle, with 1-cycle latency and no bypass.
REQ-020 SHALL assert redirect = valid_e & branch_e & !flush_e & !stall_e & (cond_ex != pred_taken_e).
REQ-021 SHALL, on a commit, register {pcsrc_m, regwrite_m, memwrite_m} = {pcs_e, regw_e, memw_e} with valid_m=1.
REQ-022 SHALL, when there is no commit (invalid, failed condition, stall or flush), register pcsrc_m=regwrite_m=memwrite_m=0 and valid_m=1 only for a failed condition that is neither stalled nor flushed.
REQ-023 SHALL give flush_e priority over stall_e when both are asserted: bubble into Memory and no flag write.
REQ-024 SHALL let a failed-condition instruction never write flags, even when flagw_e is non-zero.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously force flags=4'b0000, valid_m=0, pcsrc_m=0, regwrite_m=0, memwrite_m=0 and all counters to 0.
REQ-026 SHALL resume normal operation on the first rising clk after reset_n deasserts; an instruction present during reset SHALL be lost without side effects.

Configuration
REQ-027 SHALL, when macro COND_UNIT_PERF_EN is defined, add outputs cnt_commit, cnt_squash and cnt_mispred, each CNT_W bits, counting commits, failed-condition valid instructions and redirect cycles respectively; each SHALL saturate at all-ones and never wrap.
REQ-028 SHALL, without COND_UNIT_PERF_EN, have no counter ports or logic, with all other behaviour identical.

Verification
REQ-029 SHALL pass: reset, then ADDS (flagw=11, alu_flags=0100, cond=1110) committed -> next cycle flags=0100; following EQ instruction -> cond_ex=1.
REQ-030 SHALL pass: with flags=1001, ANDS with flagw=10 and alu_flags=0110 -> flags=0101, with C and V kept.
REQ-031 SHALL pass: with flags=0000, BEQ with branch_e=1 and pred_taken_e=1 -> cond_ex=0, redirect=1, pcsrc_m=0 and valid_m=1 next cycle.
REQ-032 SHALL pass: CMP (flagw=11) with stall_e=1 and flush_e=1 together -> flags unchanged, valid_m=0, redirect=0.
REQ-033 SHALL pass: reset_n pulled low mid-cycle with regw_e=1 committing -> regwrite_m=0 and flags=0000 immediately, no clock needed.
REQ-034 SHALL pass, with COND_UNIT_PERF_EN and CNT_W=4: 20 consecutive commits -> cnt_commit=15, held at 15.
